// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file:
// default geometry and the clear-controller state encoding.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NREGS_DEF  = 16;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential clear controller: walks every index once, one per cycle,
// issuing a zero-write strobe while busy.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately ignored here
                    idx <= idx + ADDR_W'(1);
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = busy;
    assign clr_idx = idx;

endmodule

// File: rtl/param_regfile.sv
// Two-read / two-write register file with registered reads, optional
// write-to-read forwarding and a sequential hardware clear.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              clr_req,
    output logic              busy,
    output logic [DATA_W-1:0] r_last
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] mem [NREGS];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              we1;
    logic              we2;
    logic [DATA_W-1:0] nxt1;
    logic [DATA_W-1:0] nxt2;
    logic [DATA_W-1:0] nxt_last;

    regfile_clear_ctrl #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    assign we1 = wr_en1 && !busy;
    assign we2 = wr_en2 && !busy;

    // Later checks take precedence: port 2 beats port 1, clear beats both.
    function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = mem[a];
        if (BYPASS != 0) begin
            if (we1 && a == wr_addr1) v = wr_data1;
            if (we2 && a == wr_addr2) v = wr_data2;
            if (clr_we && a == clr_idx) v = '0;
        end
        return v;
    endfunction

    always_comb begin
        nxt1     = rd_sel(rd_addr1);
        nxt2     = rd_sel(rd_addr2);
        nxt_last = rd_sel(LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            rd_data1 <= '0;
            rd_data2 <= '0;
            r_last   <= '0;
        end else begin
            if (clr_we) mem[clr_idx] <= '0;
            if (we1) mem[wr_addr1] <= wr_data1;
            if (we2) mem[wr_addr2] <= wr_data2;
            rd_data1 <= nxt1;
            rd_data2 <= nxt2;
            r_last   <= nxt_last;
        end
    end

endmodule
